wb_mem_port: RTL
================

// Module: wb_mem_port
// PURPOSE
//  Parametrised Wishbone B4 master for the core's fetch/load/store traffic, replacing the single-beat access path.
//  Adds byte-lane SEL_O, sign/zero extension, misalignment detection, bounded RTY retry, bus timeout, and a
//  one-line fetch buffer filled by incrementing bursts. Sits between control_unit and the external Wishbone bus.
// PARAMETERS
//  BURST_LEN   4    words per fetch line; power of 2, 2..16
//  MAX_RETRY   3    RTY reissues before BUS_RETRY error; 0 = first RTY is an error
//  TIMEOUT     255  cycles of STB without ACK/ERR/RTY before TIMEOUT error; 0 disables
// PORTS
//  clk        in   1   clock
//  rst        in   1   reset, asynchronous, active-high
//  req_valid  in   1   request strobe, sampled when req_ready=1
//  req_ready  out  1   high only in IDLE
//  req_op     in   2   mem_op_t: MEM_FETCH / MEM_LOAD / MEM_STORE
//  req_funct3 in   3   LB/LH/LW/LBU/LHU or SB/SH/SW; ignored for fetch (word)
//  req_addr   in   32  byte address
//  req_wdata  in   32  store data, low-aligned
//  rsp_valid  out  1   one-cycle completion pulse; no backpressure
//  rsp_data   out  32  fetched word or extended load data; 0 for stores/errors
//  rsp_err    out  2   mem_err_t: ERR_NONE/ERR_MISALIGN/ERR_BUS/ERR_RETRY (ERR_TIMEOUT shares ERR_BUS + rsp_tmo)
//  rsp_tmo    out  1   qualifies ERR_BUS as timeout
//  ACK ERR RTY in 1; STB CYC WE out 1; ADR out 32; DAT_I in 32; DAT_O out 32; CTI_O out 3; SEL_O out 4
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, line_valid=0, STB=CYC=WE=0, ADR=DAT_O=0, SEL_O=0, CTI_O=3'b000,
//   req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=ERR_NONE, retry/timeout counters=0. Aborts any bus cycle.
//  FSM: IDLE, SINGLE, BURST, BACKOFF, RESP.
//  IDLE, accept (cycle 0): fetch hit (line_valid, tag==addr[31:log2(BURST_LEN*4)]) -> RESP, rsp_valid at cycle 1.
//   Misaligned (LH/LHU/SH addr[0]!=0; LW/SW/fetch addr[1:0]!=0) -> RESP with ERR_MISALIGN, no bus activity.
//   Fetch miss -> BURST; load/store -> SINGLE. CYC/STB rise cycle 1.
//  SINGLE: CTI_O=3'b000, WE=1 for store; SEL_O from size+addr[1:0]; DAT_O = store data replicated to all lanes.
//   ACK sampled at cycle n -> CYC/STB drop cycle n+1, rsp_valid at n+1 (single load min latency 2).
//   Load: select lane by addr[1:0], sign-extend LB/LH, zero-extend LBU/LHU.
//   Store to address inside buffered line -> line_valid cleared at ACK.
//  BURST: ADR = line base + 4*beat, beat advances on ACK; CTI_O=3'b010 for beats 0..BURST_LEN-2, 3'b111 on last.
//   SEL_O=4'hF, WE=0. Each ACK writes line[beat]. After last ACK: line_valid=1, tag set, rsp_data=requested word,
//   rsp_valid next cycle. CYC held continuously across beats.
//  RTY (SINGLE/BURST): STB, CYC drop one cycle (BACKOFF), retry_cnt++, reissue same beat (burst resumes, not
//   restarts). retry_cnt > MAX_RETRY -> RESP, ERR_RETRY. retry_cnt clears on any ACK.
//  ERR: drop CYC/STB next cycle, RESP with ERR_BUS; in BURST line_valid=0 (partial line discarded).
//  Timeout: counter runs while STB=1, clears on ACK/RTY; reaching TIMEOUT -> drop CYC, ERR_BUS, rsp_tmo=1.
//  Simultaneous ACK+ERR/RTY: ERR wins, then RTY, then ACK. req_valid outside IDLE ignored.
//  RESP: rsp_valid=1 exactly one cycle, then IDLE; rsp_err/rsp_tmo valid only with rsp_valid, else ERR_NONE/0.
// STRUCTURE
//  global_pkg: mem_op_t, mem_err_t, CTI_CLASSIC/CTI_INCR/CTI_END constants, funct3 size constants (F3_LB..F3_SW).
//  Sub-module wb_lane_align (combinational): size+addr[1:0] -> SEL_O, misalign flag, store replication,
//   load lane select + extension. Line buffer is a flop array in wb_mem_port.
// TESTING
//  LB addr 0x103, DAT_I=0x80FF_FF00, ACK after 2 waits -> SEL_O=4'b1000, rsp_data=0xFFFF_FF80, ERR_NONE.
//  Fetch 0x208 cold -> 4 beats ADR 0x200..0x20C, CTI 010,010,010,111, rsp word 2; fetch 0x20C -> rsp at cycle 1, no CYC.
//  SH addr 0x201 -> ERR_MISALIGN at cycle 1, CYC never asserted; SW to 0x204 after fill -> next fetch 0x200 misses.
//  RTY 3 times then ACK (MAX_RETRY=3) -> success; RTY 4 times -> ERR_RETRY, CYC low after.
//  Burst ERR on beat 2 -> ERR_BUS, line_valid=0; no response for TIMEOUT=8 -> ERR_BUS+rsp_tmo after 8 STB cycles.
//  rst asserted mid-burst -> CYC/STB low same cycle (async), req_ready=1, following fetch misses.

Source files
------------

// File: rtl/wb_mem_port_pkg.sv
// Shared types and constants for the Wishbone memory port.
package wb_mem_port_pkg;

  typedef enum logic [1:0] {
    MEM_FETCH = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_BUS      = 2'd2,
    ERR_RETRY    = 2'd3
  } mem_err_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SINGLE  = 3'd1,
    S_BURST   = 3'd2,
    S_BACKOFF = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage

// File: rtl/wb_mem_port_lane_align.sv
// Byte-lane helper: access size and address low bits to SEL, misalignment,
// store-data replication and load-data lane select with extension.
module wb_lane_align
  import wb_mem_port_pkg::*;
(
  input  logic        is_word,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  sel,
  output logic        misalign,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [1:0]  size_s;
  logic [31:0] shifted_s;

  // Decode size (fetch is always a word) and derive all lane-dependent values.
  always_comb begin
    sel       = 4'h0;
    misalign  = 1'b0;
    wdata_rep = 32'h0;
    rdata_ext = 32'h0;
    size_s    = 2'd2;
    shifted_s = rdata >> {addr_lo, 3'b000};
    if (is_word) begin
      size_s = 2'd2;
    end else begin
      size_s = funct3[1:0];
    end
    case (size_s)
      2'd0: begin
        sel       = 4'b0001 << addr_lo;
        misalign  = 1'b0;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = funct3[2] ? {24'h0, shifted_s[7:0]}
                              : {{24{shifted_s[7]}}, shifted_s[7:0]};
      end
      2'd1: begin
        sel       = addr_lo[1] ? 4'b1100 : 4'b0011;
        misalign  = addr_lo[0];
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = funct3[2] ? {16'h0, shifted_s[15:0]}
                              : {{16{shifted_s[15]}}, shifted_s[15:0]};
      end
      default: begin
        sel       = 4'hF;
        misalign  = (addr_lo != 2'b00);
        wdata_rep = wdata;
        rdata_ext = rdata;
      end
    endcase
  end

endmodule

// File: rtl/wb_mem_port.sv
// Wishbone B4 master for fetch/load/store traffic with a one-line fetch buffer,
// bounded RTY retry and an STB timeout.
module wb_mem_port
  import wb_mem_port_pkg::*;
#(
  parameter int BURST_LEN = 4,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_err,
  output logic        rsp_tmo,
  input  logic        ACK,
  input  logic        ERR,
  input  logic        RTY,
  output logic        STB,
  output logic        CYC,
  output logic        WE,
  output logic [31:0] ADR,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic [2:0]  CTI_O,
  output logic [3:0]  SEL_O
);

  localparam int OFF_W = $clog2(BURST_LEN * 4);
  localparam int IDX_W = $clog2(BURST_LEN);
  localparam int TAG_W = 32 - OFF_W;
  localparam logic [IDX_W-1:0] LAST_BEAT   = IDX_W'(BURST_LEN - 1);
  localparam logic [7:0]       MAX_RETRY_C = 8'(MAX_RETRY);
  localparam logic [15:0]      TMO_LAST_C  = 16'(TIMEOUT - 1);
  localparam bit               TMO_EN      = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d, stb_q, stb_d, we_q, we_d;
  logic [31:0]       adr_q, adr_d, dat_o_q, dat_o_d;
  logic [3:0]        sel_q, sel_d;
  logic [2:0]        cti_q, cti_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic [7:0]        retry_q, retry_d;
  logic [15:0]       tmo_q, tmo_d;
  logic [1:0]        op_q, op_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       addr_q, addr_d;
  logic              line_valid_q, line_valid_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [31:0]       line_q [BURST_LEN];
  logic              line_wr_s;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_tmo_q, rsp_tmo_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  mem_err_t          rsp_err_q, rsp_err_d;

  logic              al_word_s, misalign_s;
  logic [2:0]        al_f3_s;
  logic [1:0]        al_lo_s;
  logic [3:0]        sel_s;
  logic [31:0]       wrep_s, rext_s;
  logic              hit_s, bus_on_s;
  logic [IDX_W-1:0]  req_idx_s, cur_idx_s;

  assign req_idx_s = req_addr[OFF_W-1:2];
  assign cur_idx_s = addr_q[OFF_W-1:2];
  assign hit_s     = line_valid_q && (tag_q == req_addr[31:OFF_W]);

  // Lane logic sees the live request while idle and the latched request during a transfer.
  always_comb begin
    al_word_s = 1'b0;
    al_f3_s   = 3'b000;
    al_lo_s   = 2'b00;
    if (state_q == S_IDLE) begin
      al_word_s = (req_op == MEM_FETCH);
      al_f3_s   = req_funct3;
      al_lo_s   = req_addr[1:0];
    end else begin
      al_word_s = (op_q == MEM_FETCH);
      al_f3_s   = f3_q;
      al_lo_s   = addr_q[1:0];
    end
  end

  wb_lane_align u_align (
    .is_word   (al_word_s),
    .funct3    (al_f3_s),
    .addr_lo   (al_lo_s),
    .wdata     (req_wdata),
    .rdata     (DAT_I),
    .sel       (sel_s),
    .misalign  (misalign_s),
    .wdata_rep (wrep_s),
    .rdata_ext (rext_s)
  );

  // Next-state and next-output logic; bus responses ranked ERR > RTY > ACK > timeout.
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_o_d      = dat_o_q;
    sel_d        = sel_q;
    cti_d        = cti_q;
    beat_d       = beat_q;
    retry_d      = retry_q;
    tmo_d        = tmo_q;
    op_d         = op_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    line_valid_d = line_valid_q;
    tag_d        = tag_q;
    line_wr_s    = 1'b0;
    rsp_valid_d  = 1'b0;
    rsp_data_d   = 32'h0;
    rsp_err_d    = ERR_NONE;
    rsp_tmo_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          retry_d = 8'd0;
          tmo_d   = 16'd0;
          if (misalign_s) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_MISALIGN;
          end else if ((req_op == MEM_FETCH) && hit_s) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = line_q[req_idx_s];
          end else if (req_op == MEM_FETCH) begin
            state_d      = S_BURST;
            we_d         = 1'b0;
            sel_d        = 4'hF;
            beat_d       = '0;
            adr_d        = {req_addr[31:OFF_W], {OFF_W{1'b0}}};
            cti_d        = CTI_INCR;
            line_valid_d = 1'b0;
          end else begin
            state_d = S_SINGLE;
            we_d    = (req_op == MEM_STORE);
            sel_d   = sel_s;
            adr_d   = {req_addr[31:2], 2'b00};
            dat_o_d = wrep_s;
            cti_d   = CTI_CLASSIC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SINGLE, S_BURST: begin
        if (ERR) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_BUS;
          tmo_d       = 16'd0;
          if (state_q == S_BURST) begin
            line_valid_d = 1'b0;
          end else begin
            line_valid_d = line_valid_q;
          end
        end else if (RTY) begin
          tmo_d = 16'd0;
          if (retry_q >= MAX_RETRY_C) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = ERR_RETRY;
          end else begin
            retry_d = retry_q + 8'd1;
            state_d = S_BACKOFF;
          end
        end else if (ACK) begin
          retry_d = 8'd0;
          tmo_d   = 16'd0;
          if (state_q == S_SINGLE) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            if (op_q == MEM_STORE) begin
              rsp_data_d = 32'h0;
              if (line_valid_q && (tag_q == addr_q[31:OFF_W])) begin
                line_valid_d = 1'b0;
              end else begin
                line_valid_d = line_valid_q;
              end
            end else begin
              rsp_data_d = rext_s;
            end
          end else begin
            line_wr_s = 1'b1;
            if (beat_q == LAST_BEAT) begin
              state_d      = S_RESP;
              rsp_valid_d  = 1'b1;
              line_valid_d = 1'b1;
              tag_d        = addr_q[31:OFF_W];
              rsp_data_d   = (cur_idx_s == beat_q) ? DAT_I : line_q[cur_idx_s];
            end else begin
              beat_d = beat_q + IDX_W'(1);
              adr_d  = adr_q + 32'd4;
              cti_d  = ((beat_q + IDX_W'(1)) == LAST_BEAT) ? CTI_END : CTI_INCR;
            end
          end
        end else if (TMO_EN && (tmo_q == TMO_LAST_C)) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = ERR_BUS;
          rsp_tmo_d   = 1'b1;
          tmo_d       = 16'd0;
          if (state_q == S_BURST) begin
            line_valid_d = 1'b0;
          end else begin
            line_valid_d = line_valid_q;
          end
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_BACKOFF: begin
        if (op_q == MEM_FETCH) begin
          state_d = S_BURST;
        end else begin
          state_d = S_SINGLE;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    bus_on_s    = (state_d == S_SINGLE) || (state_d == S_BURST);
    cyc_d       = bus_on_s;
    stb_d       = bus_on_s;
    req_ready_d = (state_d == S_IDLE);
  end

  // State, bus outputs, response outputs and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      dat_o_q      <= 32'h0;
      sel_q        <= 4'h0;
      cti_q        <= CTI_CLASSIC;
      beat_q       <= '0;
      retry_q      <= 8'd0;
      tmo_q        <= 16'd0;
      op_q         <= 2'd0;
      f3_q         <= 3'd0;
      addr_q       <= 32'h0;
      line_valid_q <= 1'b0;
      tag_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'h0;
      rsp_err_q    <= ERR_NONE;
      rsp_tmo_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_o_q      <= dat_o_d;
      sel_q        <= sel_d;
      cti_q        <= cti_d;
      beat_q       <= beat_d;
      retry_q      <= retry_d;
      tmo_q        <= tmo_d;
      op_q         <= op_d;
      f3_q         <= f3_d;
      addr_q       <= addr_d;
      line_valid_q <= line_valid_d;
      tag_q        <= tag_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      rsp_tmo_q    <= rsp_tmo_d;
    end
  end

  // Fetch line storage, one word written per acknowledged burst beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BURST_LEN; i++) begin
        line_q[i] <= 32'h0;
      end
    end else if (line_wr_s) begin
      line_q[beat_q] <= DAT_I;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_tmo   = rsp_tmo_q;
  assign CYC       = cyc_q;
  assign STB       = stb_q;
  assign WE        = we_q;
  assign ADR       = adr_q;
  assign DAT_O     = dat_o_q;
  assign SEL_O     = sel_q;
  assign CTI_O     = cti_q;

endmodule
